// File: rtl/md_hazard_ctrl.sv
// rtl/md_hazard_ctrl.sv - multiply/divide sequencer and HI/LO interlock
//
// Decodes the E-stage instruction and launches the multi-cycle MD unit. It
// counts the unit's latency, pulses the HI/LO write when the result is ready,
// and stalls the D stage for any MD-class instruction while the unit is busy.
//
// Optional feature: define MD_CANCEL_EN to honour the cancel input.
//
// Ports:
//   clk       rising-edge clock
//   reset     synchronous reset, active-low
//   IR_D      instruction in D stage
//   IR_E      instruction in E stage
//   valid_E   IR_E is a real instruction (0 = bubble/flushed)
//   cancel    abort in-flight operation (MD_CANCEL_EN builds only)
//   md_start  one-cycle launch pulse to the MD datapath (combinational)
//   md_op     latched op: 00 mult, 01 multu, 10 div, 11 divu
//   md_busy   MD unit occupied (combinational)
//   stall_D   freeze PC and D register, bubble into E
//   hilo_we   write HI/LO from the MD result this cycle

module md_hazard_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] IR_D,
    input  logic [31:0] IR_E,
    input  logic        valid_E,
    input  logic        cancel,
    output logic        md_start,
    output logic [1:0]  md_op,
    output logic        md_busy,
    output logic        stall_D,
    output logic        hilo_we
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // The counter is loaded with N-1 so that cnt reaches zero exactly N
    // cycles after the launch cycle.
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;

    logic special_e;
    logic special_d;
    logic md_e;
    logic mdcls_d;
    logic cancel_act;

    // mult/multu/div/divu share funct 0110xx; mfhi/mthi/mflo/mtlo share 0100xx.
    assign special_e = (IR_E[31:26] == 6'b000000);
    assign special_d = (IR_D[31:26] == 6'b000000);
    assign md_e      = valid_E & special_e & (IR_E[5:2] == 4'b0110);
    assign mdcls_d   = special_d & ((IR_D[5:2] == 4'b0110) | (IR_D[5:2] == 4'b0100));

`ifdef MD_CANCEL_EN
    assign cancel_act = cancel;
`else
    assign cancel_act = 1'b0;
`endif

    assign md_start = (state == IDLE) & md_e & ~cancel_act;
    assign md_busy  = md_start | (state == BUSY);
    assign stall_D  = mdcls_d & md_busy;
    // A reset asserted in the completion cycle also aborts the write.
    assign hilo_we  = (state == BUSY) & (cnt == '0) & ~cancel_act & reset;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            md_op <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    if (md_start) begin
                        md_op <= IR_E[1:0];
                        cnt   <= IR_E[1] ? DIV_LOAD : MULT_LOAD;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    // A new md_E arriving here is ignored; the pipeline
                    // holds further MD ops in D via stall_D.
                    if (cancel_act) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    logic unused_bits;
    assign unused_bits = ^{IR_D[25:6], IR_E[25:6], cancel};

endmodule
